// File: rtl/cnn_accel_pkg.sv
// Shared accelerator constants and the result-writer state encoding.
package cnn_accel_pkg;

  localparam int unsigned BUS_ADDR_WIDTH = 32;
  localparam int unsigned BUS_DATA_WIDTH = 64;
  localparam int unsigned BUS_WE_WIDTH   = BUS_DATA_WIDTH / 8;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned COUNT_WIDTH    = 13;

  // Writer FSM encoding
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t StIdle  = 2'd0;
  localparam wr_state_t StFill  = 2'd1;
  localparam wr_state_t StWrite = 2'd2;
  localparam wr_state_t StDone  = 2'd3;

  // Byte enables for the low and high 32-bit lanes of a bus word
  localparam logic [BUS_WE_WIDTH-1:0] LANE0_WE = 8'h0F;
  localparam logic [BUS_WE_WIDTH-1:0] LANE1_WE = 8'hF0;

endpackage

// File: rtl/cnn_result_writer_if.sv
// Control, result-stream and memory-write signals of the result writer.
interface cnn_result_writer_if import cnn_accel_pkg::*; ();

  // Software control
  logic                      startIn;
  logic [BUS_ADDR_WIDTH-1:0] baseAddrIn;
  logic [COUNT_WIDTH-1:0]    countIn;
  logic                      busyOut;
  logic                      doneOut;
  // Result stream
  logic [DATA_WIDTH-1:0]     dataIn;
  logic                      validIn;
  logic                      readyOut;
  // Memory write port
  logic [BUS_ADDR_WIDTH-1:0] addrOut;
  logic [BUS_WE_WIDTH-1:0]   wrEnOut;
  logic [BUS_DATA_WIDTH-1:0] wrDataOut;
  logic                      wrValidOut;
  logic                      wrReadyIn;

  // Writer side: drains the stream and initiates bus writes
  modport master (
    input  startIn, baseAddrIn, countIn, dataIn, validIn, wrReadyIn,
    output busyOut, doneOut, readyOut, addrOut, wrEnOut, wrDataOut, wrValidOut
  );

  // Environment side: software, accelerator FIFO and memory
  modport slave (
    output startIn, baseAddrIn, countIn, dataIn, validIn, wrReadyIn,
    input  busyOut, doneOut, readyOut, addrOut, wrEnOut, wrDataOut, wrValidOut
  );

endinterface

// File: rtl/cnn_result_writer.sv
// Packs pairs of 32-bit results into 64-bit bus writes starting at a programmed address.
module cnn_result_writer import cnn_accel_pkg::*; (
  input  logic                  clkIn,
  input  logic                  rstIn,
  cnn_result_writer_if.master   wr_if
);

  wr_state_t                 state_q, state_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]    rem_q, rem_d;
  logic                      lane_q, lane_d;
  logic [BUS_DATA_WIDTH-1:0] buf_q, buf_d;
  logic [BUS_WE_WIDTH-1:0]   en_q, en_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      wvalid_q, wvalid_d;

  // Word alignment drops the low address bits.
  logic unused_base;
  assign unused_base = ^wr_if.baseAddrIn[1:0];

  // Next-state: FSM, pack buffer, remaining count and write address
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    en_d    = en_q;
    unique case (state_q)
      StIdle: begin
        if (wr_if.startIn) begin
          addr_d  = {wr_if.baseAddrIn[BUS_ADDR_WIDTH-1:3], 3'b000};
          rem_d   = wr_if.countIn;
          lane_d  = wr_if.baseAddrIn[2];
          buf_d   = '0;
          en_d    = '0;
          state_d = (wr_if.countIn == '0) ? StDone : StFill;
        end
      end
      StFill: begin
        // readyOut is high throughout FILL, so validIn alone marks a transfer
        if (wr_if.validIn) begin
          if (lane_q) begin
            buf_d[BUS_DATA_WIDTH-1:DATA_WIDTH] = wr_if.dataIn;
            en_d = en_q | LANE1_WE;
          end else begin
            buf_d[DATA_WIDTH-1:0] = wr_if.dataIn;
            en_d = en_q | LANE0_WE;
          end
          rem_d = rem_q - COUNT_WIDTH'(1);
          if (lane_q || rem_q == COUNT_WIDTH'(1)) begin
            state_d = StWrite;
          end else begin
            lane_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (wr_if.wrReadyIn) begin
          addr_d  = addr_q + BUS_ADDR_WIDTH'(8);
          buf_d   = '0;
          en_d    = '0;
          lane_d  = 1'b0;
          state_d = (rem_q == '0) ? StDone : StFill;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Status outputs are registered copies of the upcoming state
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
    wvalid_d = (state_d == StWrite);
  end

  // State and registered outputs; reset aborts any transfer in flight
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rem_q    <= '0;
      lane_q   <= 1'b0;
      buf_q    <= '0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      buf_q    <= buf_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wvalid_q <= wvalid_d;
    end
  end

  assign wr_if.readyOut   = (state_q == StFill);
  assign wr_if.busyOut    = busy_q;
  assign wr_if.doneOut    = done_q;
  assign wr_if.addrOut    = addr_q;
  assign wr_if.wrEnOut    = en_q;
  assign wr_if.wrDataOut  = buf_q;
  assign wr_if.wrValidOut = wvalid_q;

endmodule

// File: tb/tb_cnn_result_writer.sv
// Bench for cnn_result_writer: directed and randomized transfers against a word-level model.
module tb_cnn_result_writer;

  logic clk;
  logic rst;

  cnn_result_writer_if bus ();

  cnn_result_writer dut (
    .clkIn (clk),
    .rstIn (rst),
    .wr_if (bus)
  );

  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  logic [31:0] stim_q[$];
  logic [31:0] exp_addr[$];
  logic [63:0] exp_data[$];
  logic [7:0]  exp_we[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: element i lands in bus word (b2+i)/2, half (b2+i)%2, where b2 = base[2]
  task automatic build_expected(input logic [31:0] base, input int cnt);
    int first;
    int nw;
    first = int'(base[2]);
    nw = (cnt == 0) ? 0 : (first + cnt + 1) / 2;
    for (int w = 0; w < nw; w++) begin
      logic [63:0] d;
      logic [7:0]  we;
      d  = '0;
      we = '0;
      for (int i = 0; i < cnt; i++) begin
        if ((first + i) / 2 == w) begin
          if ((first + i) % 2 == 1) begin
            d[63:32] = stim_q[i];
            we = we | 8'hF0;
          end else begin
            d[31:0] = stim_q[i];
            we = we | 8'h0F;
          end
        end
      end
      exp_addr.push_back((base & 32'hFFFF_FFF8) + 32'(8 * w));
      exp_data.push_back(d);
      exp_we.push_back(we);
    end
  endtask

  task automatic run_xfer(input logic [31:0] base, input int cnt, input int stall, input bit rnd);
    int idx;
    int cyc;
    int stall_left;
    bit done_seen;
    bit pend;
    logic [31:0] p_addr;
    logic [63:0] p_data;
    logic [7:0]  p_we;
    idx = 0;
    cyc = 0;
    stall_left = 0;
    done_seen = 0;
    pend = 0;
    p_addr = '0;
    p_data = '0;
    p_we = '0;
    while (stim_q.size() < cnt) stim_q.push_back($urandom);
    build_expected(base, cnt);
    @(negedge clk);
    bus.startIn = 1'b1;
    bus.baseAddrIn = base;
    bus.countIn = 13'(cnt);
    @(negedge clk);
    bus.startIn = 1'b0;
    bus.baseAddrIn = $urandom;
    bus.countIn = 13'($urandom);
    chk("busy_after_start", 64'(bus.busyOut), 64'd1);
    while (!done_seen && cyc < 2000) begin
      if (pend) begin
        chk("stall_valid", 64'(bus.wrValidOut), 64'd1);
        chk("stall_addr", 64'(bus.addrOut), 64'(p_addr));
        chk("stall_data", bus.wrDataOut, p_data);
        chk("stall_we", 64'(bus.wrEnOut), 64'(p_we));
      end
      if (bus.wrValidOut) chk("ready_in_write", 64'(bus.readyOut), 64'd0);
      if (bus.doneOut) begin
        done_seen = 1;
        chk("busy_in_done", 64'(bus.busyOut), 64'd1);
        chk("writes_left_at_done", 64'(exp_addr.size()), 64'd0);
        chk("elems_at_done", 64'(idx), 64'(cnt));
        bus.validIn = 1'b0;
        bus.wrReadyIn = 1'b0;
      end else begin
        // A pending stream element stays presented until taken
        if (!(bus.validIn && !bus.readyOut)) begin
          bus.validIn = (idx < cnt) && (rnd ? ($urandom_range(3) != 0) : 1'b1);
          bus.dataIn = bus.validIn ? stim_q[idx] : $urandom;
        end
        if (bus.readyOut && bus.validIn) idx++;
        if (bus.wrValidOut && !pend) stall_left = stall;
        if (stall_left > 0) begin
          bus.wrReadyIn = 1'b0;
          stall_left--;
        end else begin
          bus.wrReadyIn = rnd ? 1'($urandom_range(1)) : 1'b1;
        end
        if (bus.wrValidOut && bus.wrReadyIn) begin
          chk("write_expected", 64'(exp_addr.size() > 0), 64'd1);
          if (exp_addr.size() > 0) begin
            chk("wr_addr", 64'(bus.addrOut), 64'(exp_addr.pop_front()));
            chk("wr_data", bus.wrDataOut, exp_data.pop_front());
            chk("wr_we", 64'(bus.wrEnOut), 64'(exp_we.pop_front()));
          end
          pend = 0;
        end else begin
          pend = bus.wrValidOut;
          p_addr = bus.addrOut;
          p_data = bus.wrDataOut;
          p_we = bus.wrEnOut;
        end
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("done_one_cycle", 64'(bus.doneOut), 64'd0);
    chk("busy_back_idle", 64'(bus.busyOut), 64'd0);
    stim_q.delete();
    exp_addr.delete();
    exp_data.delete();
    exp_we.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busyOut), 64'd0);
    chk({tag, "_done"}, 64'(bus.doneOut), 64'd0);
    chk({tag, "_ready"}, 64'(bus.readyOut), 64'd0);
    chk({tag, "_addr"}, 64'(bus.addrOut), 64'd0);
    chk({tag, "_we"}, 64'(bus.wrEnOut), 64'd0);
    chk({tag, "_data"}, bus.wrDataOut, 64'd0);
    chk({tag, "_wvalid"}, 64'(bus.wrValidOut), 64'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus.startIn = 1'b0;
    bus.baseAddrIn = '0;
    bus.countIn = '0;
    bus.dataIn = '0;
    bus.validIn = 1'b0;
    bus.wrReadyIn = 1'b0;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Four aligned elements, bus always ready
    stim_q.push_back(32'h3F80_0000);
    stim_q.push_back(32'h4000_0000);
    stim_q.push_back(32'h4040_0000);
    stim_q.push_back(32'h4080_0000);
    run_xfer(32'h0000_1000, 4, 0, 0);

    // Odd tail
    run_xfer(32'h0000_2000, 3, 0, 0);

    // Misaligned head
    run_xfer(32'h0000_1004, 2, 0, 0);

    // Write backpressure for 5 cycles on every word
    run_xfer(32'h0000_4000, 5, 5, 0);

    // Empty transfer
    run_xfer(32'h0000_6000, 0, 0, 0);

    // Address wrap past the top of memory
    run_xfer(32'hFFFF_FFFC, 3, 0, 0);

    // Reset after one element of a transfer
    @(negedge clk);
    bus.startIn = 1'b1;
    bus.baseAddrIn = 32'h0000_5000;
    bus.countIn = 13'd4;
    @(negedge clk);
    bus.startIn = 1'b0;
    bus.validIn = 1'b1;
    bus.dataIn = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.validIn = 1'b0;
    chk("busy_before_abort", 64'(bus.busyOut), 64'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_abort", 64'(bus.doneOut), 64'd0);
    run_xfer(32'h0000_3000, 2, 0, 0);

    // Randomized transfers with random stream gaps and bus stalls
    for (int t = 0; t < 12; t++) begin
      logic [31:0] b;
      b = $urandom & 32'hFFFF_FFFC;
      run_xfer(b, int'($urandom_range(20)), int'($urandom_range(3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
